// File: rtl/instr_queue_ir_pkg.sv
// Shared definitions for the instruction register: default field layout
// (IIIXXXYYY) and opcode constants for the control FSM.
package ir_pkg;

  localparam int IR_OP_W  = 3;
  localparam int IR_REG_W = 3;
  localparam int IR_W     = IR_OP_W + 2*IR_REG_W;

  localparam int OP_MSB = IR_W - 1;
  localparam int RX_MSB = 2*IR_REG_W - 1;
  localparam int RY_MSB = IR_REG_W - 1;

  typedef enum logic [IR_OP_W-1:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_MVNZ = 3'd6,
    OP_JMP  = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e              op;
    logic [IR_REG_W-1:0]  rx;
    logic [IR_REG_W-1:0]  ry;
  } ir_fields_t;

endpackage

// File: rtl/instr_queue_ir_if.sv
// Fetch/control side bus of the prefetching instruction register.
interface instr_queue_ir_if #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int OP_W  = 3,
  parameter int REG_W = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     DIN;
  logic             push;
  logic             IRin;
  logic             flush;
  logic [W-1:0]     Q;
  logic             ir_valid;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] rx;
  logic [REG_W-1:0] ry;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             ovf;

  modport master (
    output DIN, push, IRin, flush,
    input  Q, ir_valid, opcode, rx, ry, count, empty, full, ovf
  );

  modport slave (
    input  DIN, push, IRin, flush,
    output Q, ir_valid, opcode, rx, ry, count, empty, full, ovf
  );
endinterface

// File: rtl/instr_queue_mem.sv
// Prefetch storage: falling-edge write, combinational read. No reset; the
// top's pointers and count decide which entries are meaningful.
module instr_queue_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(negedge gclk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue_ir.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO. All state moves on
// the falling clock edge; flush wins over push and IR load.
module instr_queue_ir
  import ir_pkg::*;
#(
  parameter int W     = IR_W,
  parameter int DEPTH = 4,
  parameter int OP_W  = IR_OP_W,
  parameter int REG_W = IR_REG_W
) (
  input  logic Clock,
  input  logic Resetn,
  instr_queue_ir_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd, wr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     q, rdata;
  logic             vld, ovf_q;
  logic             is_empty, is_full;
  logic             pop, byp, wr_en, drop;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(DEPTH));

  // A push on a full queue still fits when the same edge pops the head;
  // a push on an empty queue with IRin goes straight to the IR instead.
  always_comb begin
    pop   = bus.IRin & ~is_empty & ~bus.flush;
    byp   = bus.IRin &  is_empty & bus.push & ~bus.flush;
    wr_en = bus.push & ~bus.flush & (~is_full | bus.IRin) & ~byp;
    drop  = bus.push & ~bus.flush &  is_full & ~bus.IRin;
  end

  instr_queue_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .gclk  (Clock),
    .we    (wr_en),
    .waddr (wr),
    .wdata (bus.DIN),
    .raddr (rd),
    .rdata (rdata)
  );

  always_ff @(negedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (pop)   rd <= rd + 1'b1;
      if (wr_en) wr <= wr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Flush invalidates the IR but leaves Q as it was.
  always_ff @(negedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q     <= '0;
      vld   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= drop;
      if (bus.flush) begin
        vld <= 1'b0;
      end else if (pop) begin
        q   <= rdata;
        vld <= 1'b1;
      end else if (byp) begin
        q   <= bus.DIN;
        vld <= 1'b1;
      end else if (bus.IRin) begin
        vld <= 1'b0;
      end
    end
  end

  assign bus.Q        = q;
  assign bus.ir_valid = vld;
  assign bus.opcode   = q[W-1 -: OP_W];
  assign bus.rx       = q[2*REG_W-1 -: REG_W];
  assign bus.ry       = q[REG_W-1:0];
  assign bus.count    = cnt;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_instr_queue_ir.sv
// Directed bench for instr_queue_ir (DEPTH=4): ordering, full/overflow,
// bypass, flush priority, pointer wrap and asynchronous reset.
module tb_instr_queue_ir;
  localparam int W = 9, DEPTH = 4, OP_W = 3, REG_W = 3;

  logic Clock = 1'b0;
  logic Resetn;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 Clock = ~Clock;

  instr_queue_ir_if #(.W(W), .DEPTH(DEPTH), .OP_W(OP_W), .REG_W(REG_W)) bus ();

  instr_queue_ir #(.W(W), .DEPTH(DEPTH), .OP_W(OP_W), .REG_W(REG_W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'o%0o expected 'o%0o", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a falling edge; outputs are read at the
  // same offset after the next falling edge.
  task automatic cyc(input logic p, input logic i, input logic f, input logic [W-1:0] d);
    bus.push  = p;
    bus.IRin  = i;
    bus.flush = f;
    bus.DIN   = d;
    @(negedge Clock);
    #1;
  endtask

  initial begin
    Resetn    = 1'b0;
    bus.push  = 1'b0;
    bus.IRin  = 1'b0;
    bus.flush = 1'b0;
    bus.DIN   = '0;
    #7;
    chk("rst_q",     32'(bus.Q), 0);
    chk("rst_vld",   32'(bus.ir_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ovf",   32'(bus.ovf), 0);
    Resetn = 1'b1;
    @(negedge Clock);
    #1;

    // ordering
    cyc(1, 0, 0, 9'o123);
    cyc(1, 0, 0, 9'o456);
    cyc(1, 0, 0, 9'o701);
    chk("ord_count", 32'(bus.count), 3);
    cyc(0, 1, 0, 0);
    chk("ord_q0", 32'(bus.Q), 'o123);
    chk("ord_vld", 32'(bus.ir_valid), 1);
    cyc(0, 1, 0, 0);
    chk("ord_q1", 32'(bus.Q), 'o456);
    cyc(0, 1, 0, 0);
    chk("ord_q2", 32'(bus.Q), 'o701);
    chk("ord_op", 32'(bus.opcode), 7);
    chk("ord_rx", 32'(bus.rx), 0);
    chk("ord_ry", 32'(bus.ry), 1);
    chk("ord_empty", 32'(bus.empty), 1);
    cyc(0, 1, 0, 0);
    chk("ord_pop_empty_vld", 32'(bus.ir_valid), 0);
    chk("ord_pop_empty_q", 32'(bus.Q), 'o701);

    // full and overflow
    cyc(1, 0, 0, 9'o010);
    cyc(1, 0, 0, 9'o011);
    cyc(1, 0, 0, 9'o012);
    cyc(1, 0, 0, 9'o013);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_count", 32'(bus.count), 4);
    chk("full_ovf_pre", 32'(bus.ovf), 0);
    cyc(1, 0, 0, 9'o014);
    chk("ovf_pulse", 32'(bus.ovf), 1);
    chk("ovf_count", 32'(bus.count), 4);
    cyc(1, 1, 0, 9'o015);
    chk("ovf_one_edge", 32'(bus.ovf), 0);
    chk("fullpp_count", 32'(bus.count), 4);
    chk("fullpp_q", 32'(bus.Q), 'o010);
    cyc(0, 1, 0, 0);
    chk("drain_0", 32'(bus.Q), 'o011);
    cyc(0, 1, 0, 0);
    chk("drain_1", 32'(bus.Q), 'o012);
    cyc(0, 1, 0, 0);
    chk("drain_2", 32'(bus.Q), 'o013);
    cyc(0, 1, 0, 0);
    chk("drain_3", 32'(bus.Q), 'o015);
    chk("drain_empty", 32'(bus.empty), 1);

    // bypass
    cyc(1, 1, 0, 9'o352);
    chk("byp_q", 32'(bus.Q), 'o352);
    chk("byp_count", 32'(bus.count), 0);
    chk("byp_vld", 32'(bus.ir_valid), 1);

    // flush priority
    cyc(1, 1, 0, 9'o111);
    cyc(1, 0, 0, 9'o222);
    cyc(1, 0, 0, 9'o333);
    chk("fl_setup_count", 32'(bus.count), 2);
    chk("fl_setup_q", 32'(bus.Q), 'o111);
    cyc(1, 1, 1, 9'o444);
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_vld", 32'(bus.ir_valid), 0);
    chk("fl_q", 32'(bus.Q), 'o111);
    chk("fl_ovf", 32'(bus.ovf), 0);
    cyc(1, 0, 0, 9'o501);
    cyc(1, 0, 0, 9'o502);
    cyc(1, 0, 0, 9'o503);
    cyc(1, 0, 0, 9'o504);
    cyc(1, 0, 1, 9'o505);
    chk("fl_full_ovf", 32'(bus.ovf), 0);
    chk("fl_full_count", 32'(bus.count), 0);

    // wrap-around: one word in flight, 3*DEPTH push+pop pairs
    cyc(1, 0, 0, 9'o100);
    for (int i = 1; i <= 3*DEPTH; i++) begin
      cyc(1, 1, 0, W'(9'o100 + i));
      chk("wrap_q", 32'(bus.Q), 'o100 + i - 1);
      chk("wrap_count", 32'(bus.count), 1);
    end
    cyc(0, 1, 0, 0);
    chk("wrap_last", 32'(bus.Q), 'o100 + 3*DEPTH);

    // asynchronous reset mid-cycle with three words queued
    cyc(1, 0, 0, 9'o600);
    cyc(1, 0, 0, 9'o601);
    cyc(1, 0, 0, 9'o602);
    cyc(0, 0, 0, 0);
    chk("arst_pre_count", 32'(bus.count), 3);
    #3;
    Resetn = 1'b0;
    #1;
    chk("arst_q", 32'(bus.Q), 0);
    chk("arst_vld", 32'(bus.ir_valid), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
